// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg
// Shared definitions for the multicycle controller: the state enumeration
// (encoded in sequence order so the debug 'state' port reads 0..8), the
// opcode constants NOOP..HLT, the alu_op encodings and the width of the
// memory wait counter.
// Ports: none (package).
// Configuration: the controller honours the MC_CTRL_SWP_EN macro; nothing here
// depends on it.

package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_START0  = 4'd0,
        ST_START1  = 4'd1,
        ST_FETCH   = 4'd2,
        ST_DECODE  = 4'd3,
        ST_EXECUTE = 4'd4,
        ST_MEM     = 4'd5,
        ST_WB      = 4'd6,
        ST_WB2     = 4'd7,
        ST_HALT    = 4'd8
    } state_t;

    localparam logic [3:0] OP_NOOP = 4'd0;
    localparam logic [3:0] OP_LOD  = 4'd1;
    localparam logic [3:0] OP_STR  = 4'd2;
    localparam logic [3:0] OP_SWP  = 4'd3;
    localparam logic [3:0] OP_BRA  = 4'd4;
    localparam logic [3:0] OP_BRR  = 4'd5;
    localparam logic [3:0] OP_BNE  = 4'd6;
    localparam logic [3:0] OP_BNR  = 4'd7;
    localparam logic [3:0] OP_ALU  = 4'd8;
    localparam logic [3:0] OP_HLT  = 4'd15;

    // ALU_OP instructions use the 0x codes, every other opcode uses the ALU
    // for address arithmetic (1x); the low bit selects the immediate operand.
    localparam logic [1:0] ALU_ALU_REG = 2'b00;
    localparam logic [1:0] ALU_ALU_IMM = 2'b01;
    localparam logic [1:0] ALU_ADR_REG = 2'b10;
    localparam logic [1:0] ALU_ADR_IMM = 2'b11;

    // Wide enough for the largest allowed WAIT_MAX (255).
    localparam int WAIT_CNT_W = 8;

    function automatic logic [1:0] alu_code(input logic is_alu, input logic is_imm);
        if (is_alu) begin
            return is_imm ? ALU_ALU_IMM : ALU_ALU_REG;
        end
        return is_imm ? ALU_ADR_IMM : ALU_ADR_REG;
    endfunction

endpackage

// File: rtl/mc_wait_cnt.sv
// mc_wait_cnt
// Counts the cycles the controller spends held in MEM waiting for dm_rdy.
// Ports:
//   clk    - clock, rising edge
//   rst_f  - asynchronous active-low reset, clears the count
//   clear  - synchronous clear (asserted whenever the controller is not in MEM)
//   enable - increment for one held cycle
//   tc     - terminal count: the current held cycle is the WAIT_MAX-th one,
//            so the count would reach WAIT_MAX on this edge

module mc_wait_cnt
    import mc_ctrl_pkg::*;
#(
    parameter int WAIT_MAX = 15
) (
    input  logic clk,
    input  logic rst_f,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    logic [WAIT_CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    // Flag the cycle whose increment would reach WAIT_MAX, so the controller
    // can leave MEM on exactly the WAIT_MAX-th held cycle.
    assign tc = (count == WAIT_CNT_W'(WAIT_MAX - 1));

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl
// Multicycle processor control FSM: START0 -> START1 -> FETCH -> DECODE ->
// EXECUTE -> MEM -> WB (-> WB2) -> FETCH, with HALT on HLT or on a data
// memory timeout. Outputs are Moore decodes of the state plus the opcode/mm
// fields captured at the DECODE->EXECUTE edge; DECODE itself looks at the
// live IR fields for branch resolution.
// Ports:
//   clk, rst_f            - clock and asynchronous active-low reset
//   opcode, mm, stat      - IR opcode, IR condition/mode field, status flags
//   dm_rdy                - data memory completion
//   rf_we .. dm_req       - datapath controls; alu_op - ALU function select
//   halted, err           - in HALT / HALT was reached by memory timeout
//   state                 - current state, for debug
// Configuration: define MC_CTRL_SWP_EN to enable the two-cycle SWP writeback
// (WB -> WB2); without it SWP behaves as NOOP and WB2 is never entered.

module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int OP_W     = 4,
    parameter int CC_W     = 4,
    parameter int AM_IMM   = 8,
    parameter int WAIT_MAX = 15
) (
    input  logic            clk,
    input  logic            rst_f,
    input  logic [OP_W-1:0] opcode,
    input  logic [CC_W-1:0] mm,
    input  logic [CC_W-1:0] stat,
    input  logic            dm_rdy,
    output logic            rf_we,
    output logic            wb_sel,
    output logic            rb_sel,
    output logic            pc_sel,
    output logic            pc_write,
    output logic            pc_rst,
    output logic            ir_load,
    output logic            br_sel,
    output logic            mux_16_sel,
    output logic            dm_we,
    output logic            dm_req,
    output logic [1:0]      alu_op,
    output logic            halted,
    output logic            err,
    output logic [3:0]      state
);

    state_t          cur_state, next_state;
    logic [OP_W-1:0] op_q;
    logic [CC_W-1:0] mm_q;
    logic [CC_W-1:0] stat_q;
    logic            mem_op_q;
    logic            imm_q;
    logic            br_taken;
    logic            wait_en;
    logic            wait_tc;
    logic            timeout;

    // The status snapshot is captured with the other fields but no state after
    // DECODE needs it; folding it here documents that it is deliberately idle.
    logic unused_stat;
    assign unused_stat = ^stat_q;

    assign mem_op_q = (op_q == OP_W'(OP_LOD)) || (op_q == OP_W'(OP_STR));
    assign imm_q    = (mm_q == CC_W'(AM_IMM));

    // BRA/BRR fire when any masked flag is set, BNE/BNR when none are.
    always_comb begin
        br_taken = 1'b0;
        if ((opcode == OP_W'(OP_BRA)) || (opcode == OP_W'(OP_BRR))) begin
            br_taken = ((stat & mm) != '0);
        end else if ((opcode == OP_W'(OP_BNE)) || (opcode == OP_W'(OP_BNR))) begin
            br_taken = ((stat & mm) == '0);
        end
    end

    // A held MEM cycle is a memory access still waiting on dm_rdy; the last
    // allowed one turns into a timeout.
    assign wait_en = (cur_state == ST_MEM) && mem_op_q && !dm_rdy;
    assign timeout = wait_en && wait_tc;

    mc_wait_cnt #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_cnt (
        .clk    (clk),
        .rst_f  (rst_f),
        .clear  (cur_state != ST_MEM),
        .enable (wait_en),
        .tc     (wait_tc)
    );

    // State register; reset forces START0 immediately so every output drops
    // to its reset value without waiting for a clock.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            cur_state <= ST_START0;
        end else begin
            cur_state <= next_state;
        end
    end

    // IR fields are frozen on leaving DECODE so EXECUTE..WB are immune to the
    // IR changing underneath them. err latches a memory timeout until reset.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            op_q   <= '0;
            mm_q   <= '0;
            stat_q <= '0;
            err    <= 1'b0;
        end else begin
            if ((cur_state == ST_DECODE) && (next_state == ST_EXECUTE)) begin
                op_q   <= opcode;
                mm_q   <= mm;
                stat_q <= stat;
            end
            if (timeout) begin
                err <= 1'b1;
            end
        end
    end

    // Next-state and control decode; everything defaults to inactive.
    always_comb begin
        next_state = cur_state;
        rf_we      = 1'b0;
        wb_sel     = 1'b0;
        rb_sel     = 1'b0;
        pc_sel     = 1'b0;
        pc_write   = 1'b0;
        pc_rst     = 1'b0;
        ir_load    = 1'b0;
        br_sel     = 1'b0;
        mux_16_sel = 1'b0;
        dm_we      = 1'b0;
        dm_req     = 1'b0;
        alu_op     = 2'b00;
        halted     = 1'b0;

        case (cur_state)
            ST_START0: begin
                pc_rst     = 1'b1;
                next_state = ST_START1;
            end
            ST_START1: begin
                next_state = ST_FETCH;
            end
            ST_FETCH: begin
                pc_write   = 1'b1;
                ir_load    = 1'b1;
                next_state = ST_DECODE;
            end
            ST_DECODE: begin
                if (br_taken) begin
                    pc_sel   = 1'b1;
                    pc_write = 1'b1;
                    br_sel   = (opcode == OP_W'(OP_BRA)) || (opcode == OP_W'(OP_BNE));
                end
                rb_sel     = (opcode == OP_W'(OP_STR));
                next_state = (opcode == OP_W'(OP_HLT)) ? ST_HALT : ST_EXECUTE;
            end
            ST_EXECUTE: begin
                alu_op     = alu_code(op_q == OP_W'(OP_ALU), imm_q);
                next_state = ST_MEM;
            end
            ST_MEM: begin
                if (mem_op_q) begin
                    dm_req     = 1'b1;
                    dm_we      = (op_q == OP_W'(OP_STR));
                    mux_16_sel = imm_q;
                end
                if (timeout) begin
                    next_state = ST_HALT;
                end else if (!wait_en) begin
                    next_state = ST_WB;
                end
            end
            ST_WB: begin
                rf_we      = (op_q == OP_W'(OP_ALU)) || (op_q == OP_W'(OP_LOD));
                wb_sel     = (op_q == OP_W'(OP_LOD));
                next_state = ST_FETCH;
`ifdef MC_CTRL_SWP_EN
                if (op_q == OP_W'(OP_SWP)) begin
                    rf_we      = 1'b1;
                    next_state = ST_WB2;
                end
`endif
            end
            ST_WB2: begin
`ifdef MC_CTRL_SWP_EN
                rf_we  = 1'b1;
                rb_sel = 1'b1;
`endif
                next_state = ST_FETCH;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                next_state = ST_START0;
            end
        endcase
    end

    assign state = cur_state;

endmodule
